// File: rtl/image_stream_reader.sv
// Raster-order reader for one image of the multi-image pixel BRAM, re-emitted
// as a valid/ready pixel stream with start-of-line, end-of-line and last markers.
module image_stream_reader #(
  parameter  int NUM_IMAGES   = 4,
  parameter  int IMAGE_WIDTH  = 188,
  parameter  int IMAGE_HEIGHT = 120,
  parameter  int DATA_WIDTH   = 16,
  localparam int IMAGE_SIZE   = IMAGE_WIDTH * IMAGE_HEIGHT,
  localparam int ADDR_WIDTH   = $clog2(IMAGE_SIZE),
  localparam int SEL_WIDTH    = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SEL_WIDTH-1:0]  start_img,
  output logic                  busy,
  output logic                  done,
  output logic                  read_en,
  output logic [SEL_WIDTH-1:0]  img_sel,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_sol,
  output logic                  pix_eol,
  output logic                  pix_last
);

  localparam int COL_WIDTH = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int ROW_WIDTH = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMAGE_SIZE - 1);
  localparam logic [COL_WIDTH-1:0]  LAST_COL  = COL_WIDTH'(IMAGE_WIDTH - 1);
  localparam logic [ROW_WIDTH-1:0]  LAST_ROW  = ROW_WIDTH'(IMAGE_HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                  state_q;
  logic [SEL_WIDTH-1:0]    img_sel_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    inflight_q;
  logic                    done_q;
  logic [1:0]              occ_q;
  logic                    wr_ptr_q;
  logic                    rd_ptr_q;
  logic [DATA_WIDTH-1:0]   mem_q [2];
  logic [COL_WIDTH-1:0]    col_q;
  logic [ROW_WIDTH-1:0]    row_q;

  logic pop;
  logic read_en_d;
  logic start_ok;

  assign pix_valid = (occ_q != 2'd0);
  assign pop       = pix_valid & pix_ready;
  assign start_ok  = start && (int'(start_img) < NUM_IMAGES);

  // Credit check: buffered + in-flight words, less the one leaving now, must
  // leave room for the word this read returns next cycle.
  always_comb begin
    read_en_d = 1'b0;
    if (state_q == S_RUN) begin
      read_en_d = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      img_sel_q  <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      occ_q      <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      col_q      <= '0;
      row_q      <= '0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= read_en_d;

      if (inflight_q) begin
        mem_q[wr_ptr_q] <= data_in;
        wr_ptr_q        <= ~wr_ptr_q;
      end

      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        if (col_q == LAST_COL) begin
          col_q <= '0;
          row_q <= (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end

      case ({inflight_q, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase

      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            state_q   <= S_RUN;
            img_sel_q <= start_img;
            addr_q    <= '0;
            col_q     <= '0;
            row_q     <= '0;
          end
        end
        S_RUN: begin
          if (read_en_d) begin
            if (addr_q == LAST_ADDR) begin
              state_q <= S_DRAIN;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (pop && pix_last) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign read_en  = read_en_d;
  assign img_sel  = img_sel_q;
  assign addr     = addr_q;
  assign pix_data = pix_valid ? mem_q[rd_ptr_q] : '0;
  assign pix_sol  = pix_valid && (col_q == '0);
  assign pix_eol  = pix_valid && (col_q == LAST_COL);
  assign pix_last = pix_valid && (col_q == LAST_COL) && (row_q == LAST_ROW);

endmodule

// File: tb/tb_image_stream_reader.sv
// Bench for image_stream_reader: BRAM model, pixel scoreboard and per-scenario tasks.
module tb_image_stream_reader;

  localparam int unsigned NUM_IMAGES   = 4;
  localparam int unsigned IMAGE_WIDTH  = 188;
  localparam int unsigned IMAGE_HEIGHT = 120;
  localparam int unsigned DATA_WIDTH   = 16;
  localparam int unsigned IMAGE_SIZE   = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned ADDR_WIDTH   = $clog2(IMAGE_SIZE);
  localparam int unsigned SEL_WIDTH    = $clog2(NUM_IMAGES);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] d;
    logic sol;
    logic eol;
    logic last;
  } pix_t;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic [SEL_WIDTH-1:0]  start_img;
  logic                  busy;
  logic                  done;
  logic                  read_en;
  logic [SEL_WIDTH-1:0]  img_sel;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] pix_data;
  logic                  pix_valid;
  logic                  pix_ready;
  logic                  pix_sol;
  logic                  pix_eol;
  logic                  pix_last;

  image_stream_reader #(
    .NUM_IMAGES  (NUM_IMAGES),
    .IMAGE_WIDTH (IMAGE_WIDTH),
    .IMAGE_HEIGHT(IMAGE_HEIGHT),
    .DATA_WIDTH  (DATA_WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .start_img(start_img),
    .busy     (busy),
    .done     (done),
    .read_en  (read_en),
    .img_sel  (img_sel),
    .addr     (addr),
    .data_in  (data_in),
    .pix_data (pix_data),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_sol  (pix_sol),
    .pix_eol  (pix_eol),
    .pix_last (pix_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned gcyc = 0;
  always @(posedge clk) gcyc <= gcyc + 1;

  function automatic logic [DATA_WIDTH-1:0] bram_word(input int unsigned img, input int unsigned a);
    int unsigned w;
    w = img * IMAGE_SIZE + a;
    return w[DATA_WIDTH-1:0];
  endfunction

  initial data_in = '0;
  always @(posedge clk) if (read_en) data_in <= bram_word(32'(img_sel), 32'(addr));

  int          checks = 0;
  int          errors = 0;
  pix_t        sb[$];
  int          pop_cnt = 0;
  int unsigned last_pop_cyc = 0;
  int          outst = 0;
  logic [SEL_WIDTH-1:0] exp_sel = '0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  pix_t        prev_pix;
  pix_t        cur;
  pix_t        e;

  task automatic push_frame(input int unsigned img);
    pix_t p;
    for (int unsigned i = 0; i < IMAGE_SIZE; i++) begin
      p.d    = bram_word(img, i);
      p.sol  = (i % IMAGE_WIDTH) == 0;
      p.eol  = (i % IMAGE_WIDTH) == IMAGE_WIDTH - 1;
      p.last = (i == IMAGE_SIZE - 1);
      sb.push_back(p);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start_img = '0; pix_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({read_en, img_sel, addr, pix_valid, pix_data, pix_sol, pix_eol, pix_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got re=%b sel=%0d addr=%0d v=%b d=%h sol=%b eol=%b last=%b busy=%b done=%b exp all 0",
               read_en, img_sel, addr, pix_valid, pix_data, pix_sol, pix_eol, pix_last, busy, done);
    end
    rst = 1'b0;
  endtask

  // Full frame of image 0 with ready held high; returns in the done cycle.
  task automatic test_img0();
    int unsigned c0, first_v, done_c;
    int base;
    bit seen_v, got_done;
    @(posedge clk); #1;
    pix_ready = 1'b1; exp_sel = 2'd0;
    sb.delete(); push_frame(0);
    base = pop_cnt;
    start = 1'b1; start_img = 2'd0; c0 = gcyc;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (read_en !== 1'b1 || addr !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL img0_cycle1 got re=%b addr=%0d busy=%b exp re=1 addr=0 busy=1", read_en, addr, busy);
    end
    seen_v = 0; got_done = 0; first_v = 0; done_c = 0;
    for (int i = 0; i < int'(IMAGE_SIZE) + 20; i++) begin
      if (pix_valid && !seen_v) begin seen_v = 1; first_v = gcyc - c0; end
      if (done) begin got_done = 1; done_c = gcyc - c0; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (first_v != 3) begin
      errors++; $display("FAIL img0_first_valid_cycle got %0d exp 3", first_v);
    end
    checks++;
    if (!got_done || done_c != 3 + IMAGE_SIZE) begin
      errors++; $display("FAIL img0_done_cycle got %0d (seen=%0d) exp %0d", done_c, got_done, 3 + IMAGE_SIZE);
    end
    checks++;
    if (pop_cnt - base != int'(IMAGE_SIZE)) begin
      errors++; $display("FAIL img0_handshakes got %0d exp %0d", pop_cnt - base, IMAGE_SIZE);
    end
    checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      errors++; $display("FAIL img0_end got busy=%b left=%0d exp busy=0 left=0", busy, sb.size());
    end
  endtask

  // Image 3 started in the same cycle done of the previous frame is high.
  task automatic test_back_to_back();
    int unsigned c0, done_abs;
    bit got_done;
    exp_sel = 2'd3;
    sb.delete(); push_frame(3);
    start = 1'b1; start_img = 2'd3; c0 = gcyc;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (read_en !== 1'b1 || addr !== '0 || busy !== 1'b1 || img_sel !== 2'd3) begin
      errors++;
      $display("FAIL b2b_accept got re=%b addr=%0d busy=%b sel=%0d exp re=1 addr=0 busy=1 sel=3",
               read_en, addr, busy, img_sel);
    end
    got_done = 0; done_abs = 0;
    for (int i = 0; i < int'(IMAGE_SIZE) + 20; i++) begin
      if (done) begin got_done = 1; done_abs = gcyc; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!got_done || done_abs - c0 != 3 + IMAGE_SIZE) begin
      errors++; $display("FAIL img3_done_cycle got %0d (seen=%0d) exp %0d", done_abs - c0, got_done, 3 + IMAGE_SIZE);
    end
    checks++;
    if (done_abs - last_pop_cyc != 1) begin
      errors++; $display("FAIL img3_done_after_last got %0d cycles exp 1", done_abs - last_pop_cyc);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL img3_missing got %0d left exp 0", sb.size());
    end
  endtask

  task automatic test_backpressure();
    int base;
    bit got_done;
    @(posedge clk); #1;
    exp_sel = 2'd1;
    sb.delete(); push_frame(1);
    base = pop_cnt;
    start = 1'b1; start_img = 2'd1; pix_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    got_done = 0;
    for (int i = 0; i < 4 * int'(IMAGE_SIZE); i++) begin
      pix_ready = ($urandom_range(0, 99) < 75);
      @(posedge clk); #1;
      if (done) begin got_done = 1; break; end
    end
    pix_ready = 1'b1;
    checks++;
    if (!got_done) begin
      errors++; $display("FAIL bp_timeout got no done exp done within %0d cycles", 4 * IMAGE_SIZE);
    end
    checks++;
    if (pop_cnt - base != int'(IMAGE_SIZE) || sb.size() != 0) begin
      errors++; $display("FAIL bp_count got %0d pops %0d left exp %0d pops 0 left", pop_cnt - base, sb.size(), IMAGE_SIZE);
    end
  endtask

  task automatic test_mid_start_abort();
    int base;
    int unsigned c0;
    bit seen;
    @(posedge clk); #1;
    exp_sel = 2'd2; pix_ready = 1'b1;
    sb.delete(); push_frame(2);
    base = pop_cnt;
    start = 1'b1; start_img = 2'd2;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 1000 && (pop_cnt - base) < 200; i++) begin @(posedge clk); #1; end
    start = 1'b1; start_img = 2'd0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (img_sel !== 2'd2 || busy !== 1'b1 || (pop_cnt - base) < 200) begin
      errors++; $display("FAIL mid_start got sel=%0d busy=%b pops=%0d exp sel=2 busy=1 pops>=200", img_sel, busy, pop_cnt - base);
    end
    for (int i = 0; i < 1000 && (pop_cnt - base) < 500; i++) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({read_en, img_sel, addr, pix_valid, pix_data, pix_sol, pix_eol, pix_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL abort_outputs got re=%b sel=%0d addr=%0d v=%b d=%h sol=%b eol=%b last=%b busy=%b done=%b exp all 0",
               read_en, img_sel, addr, pix_valid, pix_data, pix_sol, pix_eol, pix_last, busy, done);
    end
    rst = 1'b0;
    sb.delete();
    exp_sel = 2'd0; push_frame(0);
    start = 1'b1; start_img = 2'd0; c0 = gcyc;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (pix_valid) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!seen || pix_data !== 16'h0000 || pix_sol !== 1'b1 || gcyc - c0 != 3) begin
      errors++; $display("FAIL restart_first got seen=%0d d=%h sol=%b cycle=%0d exp d=0000 sol=1 cycle=3",
                         seen, pix_data, pix_sol, gcyc - c0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_img = '0; pix_ready = 1'b1;
    prev_pix = '0;
    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          outst = 0; prev_valid = 1'b0;
        end else begin
          cur = {pix_data, pix_sol, pix_eol, pix_last};
          if (prev_valid && !prev_ready) begin
            checks++;
            if (pix_valid !== 1'b1 || cur !== prev_pix) begin
              errors++; $display("FAIL stall_hold got v=%b %h exp v=1 %h", pix_valid, cur, prev_pix);
            end
          end
          if (read_en) begin
            checks++;
            if (img_sel !== exp_sel || 32'(addr) >= IMAGE_SIZE) begin
              errors++; $display("FAIL read_port got sel=%0d addr=%0d exp sel=%0d addr<%0d", img_sel, addr, exp_sel, IMAGE_SIZE);
            end
            outst++;
          end
          if (pix_valid && pix_ready) begin
            checks++;
            if (sb.size() == 0) begin
              errors++; $display("FAIL sb_extra got %h exp no pixel", cur);
            end else begin
              e = sb.pop_front();
              if (cur !== e) begin
                errors++; $display("FAIL pixel #%0d got %h exp %h", pop_cnt, cur, e);
              end
            end
            pop_cnt++;
            if (pix_last) last_pop_cyc = gcyc;
            outst--;
          end
          checks++;
          if (outst > 2 || outst < 0) begin
            errors++; $display("FAIL occupancy got %0d exp 0..2", outst);
          end
          prev_valid = pix_valid; prev_ready = pix_ready; prev_pix = cur;
        end
      end
    join_none

    test_reset();
    test_img0();
    test_back_to_back();
    test_backpressure();
    test_mid_start_abort();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_stream_reader.md
# image_stream_reader

Read-side master for the multi-image pixel BRAM (`bram_images`). On a start command it scans one selected image in raster order. It drives the BRAM read port (`read_en` / `img_sel` / `addr`, 1-cycle synchronous read latency) and re-emits the pixels as a valid/ready stream with line and frame markers. Backpressure is absorbed by a 2-entry output buffer, so no read data is ever lost. This is the pixel source feeding the CNN front-end.

## Interface
- `NUM_IMAGES`, default 4: number of images held in the BRAM.
- `IMAGE_WIDTH`, default 188: pixels per line.
- `IMAGE_HEIGHT`, default 120: lines per image.
- `DATA_WIDTH`, default 16: pixel width.
- Derived: `IMAGE_SIZE` = `IMAGE_WIDTH`*`IMAGE_HEIGHT`; `ADDR_WIDTH` = $clog2(`IMAGE_SIZE`); `SEL_WIDTH` = $clog2(`NUM_IMAGES`).

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  frame request; sampled only in IDLE.
- `start_img`  in  `SEL_WIDTH`  image index captured with `start`.
- `busy`  out  1  high from the cycle after start acceptance until `done`.
- `done`  out  1  one-cycle pulse after the final pixel handshake.
- `read_en`  out  1  BRAM read strobe.
- `img_sel`  out  `SEL_WIDTH`  BRAM image select; latched for the whole frame.
- `addr`  out  `ADDR_WIDTH`  BRAM address relative to the image.
- `data_in`  in  `DATA_WIDTH`  BRAM `data_out`; valid in the cycle after a `read_en` cycle.
- `pix_data`  out  `DATA_WIDTH`  stream pixel.
- `pix_valid`  out  1  stream valid.
- `pix_ready`  in  1  stream ready.
- `pix_sol`  out  1  qualifies `pix_data` as column 0.
- `pix_eol`  out  1  qualifies `pix_data` as column `IMAGE_WIDTH`-1.
- `pix_last`  out  1  qualifies `pix_data` as the final pixel of the image.

## Operation
- FSM states:
  - IDLE to RUN on `start`=1 with `start_img` < `NUM_IMAGES`. A start with an out-of-range index is ignored and the block stays in IDLE. On acceptance, `img_sel` is latched, `addr` cleared and the counters cleared.
  - RUN: a read is issued (`read_en`=1 at the current `addr`, then `addr`+1) when occ + inflight − pop < 2.
    - occ is the buffer occupancy (0..2).
    - inflight is the read issued in the previous cycle.
    - pop = `pix_valid` & `pix_ready`.
  - RUN to DRAIN after the read at `addr` = `IMAGE_SIZE`-1 is issued. `addr` holds at `IMAGE_SIZE`-1 and does not wrap.
  - DRAIN to IDLE on the handshake of the `pix_last` pixel. The next cycle has `done`=1 and `busy`=0.
- `start` while not in IDLE is ignored.
- The buffer is a 2-entry FIFO that writes `data_in` in the cycle after each read. A write and a pop in the same cycle are both legal: occupancy is unchanged.
- By construction the buffer cannot overflow. The bench asserts that occ never exceeds 2.
- Output side:
  - `pix_valid` = (occ ≠ 0), and `pix_data` = the FIFO head.
  - Output column/row counters advance only on pop. The column wraps at `IMAGE_WIDTH`-1 and increments the row.
  - `pix_sol`, `pix_eol` and `pix_last` decode from these counters. They are meaningful only while `pix_valid`=1 and are 0 otherwise.
- `pix_data` and the markers hold stable while `pix_valid`=1 and `pix_ready`=0.
- `rst` mid-frame aborts immediately. In-flight read data is discarded and the FIFO emptied; the block re-enters IDLE.

## Timing
- Reset values:
  - `read_en`, `img_sel`, `addr` = 0.
  - `pix_valid`, `pix_data`, `pix_sol`, `pix_eol`, `pix_last` = 0.
  - `busy`, `done` = 0.
- Start latency, with the `start` accepted in cycle 0:
  - Cycle 1: `read_en`=1, `addr`=0.
  - Cycle 2: `data_in` valid.
  - Cycle 3: `pix_valid`=1.
- With `pix_ready` held at 1:
  - One pixel per cycle.
  - Last pixel valid in cycle 2+`IMAGE_SIZE`.
  - `done` in cycle 3+`IMAGE_SIZE`.
- When `pix_ready` rises after a stall, a pixel is delivered every cycle starting in that cycle.
- A new `start` is accepted in the same cycle `done`=1, since the FSM is already in IDLE.

## Test plan
BRAM model preloaded with word = (img*`IMAGE_SIZE`+addr) mod 65536. The first three scenarios have `pix_ready`=1 throughout.
- Start image 0 → first pixel 0x0000 in cycle 3; pixel 187 has `pix_eol`=1; pixel 188 = 0x00BC with `pix_sol`=1; exactly 22560 handshakes; `done` in cycle 22563.
- Start image 2 → first pixel 0xB040; `img_sel`=2 on every `read_en` cycle.
- Start image 3 → final pixel 0x607F with `pix_last`=1, `addr` never exceeds 22559, `done` one cycle after the final handshake.
- Image 1 with `pix_ready` toggling 1-0 pseudo-randomly → all 22560 pixels delivered in order with no gaps or duplicates; `pix_data` stable during stalls; occ ≤ 2.
- `start` pulsed mid-frame → ignored.
- `rst` at pixel 500 → all outputs 0 on the next cycle; a subsequent start on image 0 delivers 0x0000 first.
